// File: rtl/mult_arb_seq.sv
// Two-port arbiter and control sequencer for the shared shift-add signed multiplier datapath.
// Optional build macro MULT_FIXED_PRIO_EN selects fixed priority (requester 0 wins) instead of round robin.
module mult_arb_seq #(
    parameter int WIDTH = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       M,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       clr_xa,
    output logic       ld_b,
    output logic       add,
    output logic       sub,
    output logic       shift,
    output logic [1:0] done,
    output logic       busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_owner;
    logic          w_winner;
    logic          w_last_iter;
`ifndef MULT_FIXED_PRIO_EN
    logic          r_last_owner;
`endif

    assign w_last_iter = (r_cnt == LAST_ITER);

    always_comb begin
        w_winner = 1'b0;
        if (req == 2'b10) begin
            w_winner = 1'b1;
        end else if (req == 2'b11) begin
`ifdef MULT_FIXED_PRIO_EN
            w_winner = 1'b0;
`else
            w_winner = ~r_last_owner;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
`ifndef MULT_FIXED_PRIO_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) r_owner <= w_winner;
                end
                S_LOAD: r_cnt <= '0;
                S_SHIFT: begin
                    if (!w_last_iter) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`ifndef MULT_FIXED_PRIO_EN
                    // Round-robin history updates as the operation enters DONE.
                    else begin
                        r_last_owner <= r_owner;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        gnt    = 2'b00;
        sel    = 1'b0;
        clr_xa = 1'b0;
        ld_b   = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        shift  = 1'b0;
        done   = 2'b00;
        busy   = (r_state != S_IDLE);
        if (r_state != S_IDLE) begin
            gnt = r_owner ? 2'b10 : 2'b01;
            sel = r_owner;
        end
        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) w_next = S_LOAD;
            end
            S_LOAD: begin
                clr_xa = 1'b1;
                ld_b   = 1'b1;
                w_next = S_ADD;
            end
            S_ADD: begin
                // Final iteration weighs the multiplier sign bit negatively.
                add    = M & ~w_last_iter;
                sub    = M & w_last_iter;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                shift  = 1'b1;
                w_next = w_last_iter ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done   = r_owner ? 2'b10 : 2'b01;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_arb_seq.sv
// Directed self-checking bench for mult_arb_seq with a behavioural X/A/B shift-add datapath model.
module tb_mult_arb_seq;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic       M;
    logic [1:0] gnt;
    logic       sel;
    logic       clr_xa;
    logic       ld_b;
    logic       add;
    logic       sub;
    logic       shift;
    logic [1:0] done;
    logic       busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mult_arb_seq #(.WIDTH(8)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    (req),
        .M      (M),
        .gnt    (gnt),
        .sel    (sel),
        .clr_xa (clr_xa),
        .ld_b   (ld_b),
        .add    (add),
        .sub    (sub),
        .shift  (shift),
        .done   (done),
        .busy   (busy)
    );

    always #5 Clk = ~Clk;

    // Datapath model: per-requester operands, X/A/B registers driven by the DUT strobes.
    logic [7:0]  s_op0 = 8'h00, s_op1 = 8'h00, b_op0 = 8'h00, b_op1 = 8'h00;
    logic        dp_x = 1'b0;
    logic [7:0]  dp_a = 8'h00, dp_b = 8'h00;
    logic [7:0]  s_sel;
    logic [8:0]  add_sum, sub_sum;
    logic [15:0] product;
    logic [10:0] vec;

    assign s_sel   = sel ? s_op1 : s_op0;
    assign add_sum = {dp_a[7], dp_a} + {s_sel[7], s_sel};
    assign sub_sum = {dp_a[7], dp_a} - {s_sel[7], s_sel};
    assign M       = dp_b[0];
    assign product = {dp_a, dp_b};
    assign vec     = {gnt, sel, clr_xa, ld_b, add, sub, shift, done, busy};

    always @(posedge Clk) begin
        if (clr_xa) begin
            dp_x <= 1'b0;
            dp_a <= 8'h00;
        end
        if (ld_b) dp_b <= sel ? b_op1 : b_op0;
        if (add) begin
            dp_x <= add_sum[8];
            dp_a <= add_sum[7:0];
        end
        if (sub) begin
            dp_x <= sub_sum[8];
            dp_a <= sub_sum[7:0];
        end
        if (shift) begin
            dp_a <= {dp_x, dp_a[7:1]};
            dp_b <= {dp_a[0], dp_b[7:1]};
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected {gnt,sel,clr_xa,ld_b,add,sub,shift,done,busy} in cycle c of an op granted in cycle 0.
    function automatic logic [10:0] exp_vec(input int c, input logic own, input logic [7:0] mb);
        logic [1:0] g;
        logic       act, a, s, sh;
        int         i;
        act = (c >= 1 && c <= 18);
        g   = act ? (own ? 2'b10 : 2'b01) : 2'b00;
        a   = 1'b0;
        s   = 1'b0;
        sh  = (c >= 3 && c <= 17 && (c % 2) == 1);
        if (c >= 2 && c <= 16 && (c % 2) == 0) begin
            i = (c - 2) / 2;
            if (mb[i]) begin
                if (i == 7) s = 1'b1;
                else        a = 1'b1;
            end
        end
        return {g, act & own, c == 1, c == 1, a, s, sh, (c == 18) ? g : 2'b00, act};
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        req   = 2'b11;
        tick();
        tick();
        chk_cnt++;
        if (vec !== 11'b0) $display("FAIL reset_outputs: got %b want %b", vec, 11'b0);
        else pass_cnt++;
        req   = 2'b00;
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        s_op0 = 8'd7;
        b_op0 = 8'd3;
        req   = 2'b01;
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk_cnt++;
            if (vec !== exp_vec(c, 1'b0, 8'd3))
                $display("FAIL basic_ctrl c%0d: got %b want %b", c, vec, exp_vec(c, 1'b0, 8'd3));
            else pass_cnt++;
            if (c == 18) begin
                chk_cnt++;
                if (product !== 16'd21) $display("FAIL basic_product: got %h want %h", product, 16'd21);
                else pass_cnt++;
                req = 2'b00;
            end
        end
    endtask

    task automatic test_signed();
        s_op1 = 8'h05;
        b_op1 = 8'hFD;
        req   = 2'b10;
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk_cnt++;
            if (vec !== exp_vec(c, 1'b1, 8'hFD))
                $display("FAIL signed_ctrl c%0d: got %b want %b", c, vec, exp_vec(c, 1'b1, 8'hFD));
            else pass_cnt++;
            if (c == 16) begin
                chk_cnt++;
                if (sub !== 1'b1) $display("FAIL signed_sub_last: got %b want 1", sub);
                else pass_cnt++;
            end
            if (c == 18) begin
                chk_cnt++;
                if (product !== 16'hFFF1) $display("FAIL signed_product: got %h want %h", product, 16'hFFF1);
                else pass_cnt++;
                req = 2'b00;
            end
        end
    endtask

    task automatic test_contention();
        int         n;
        logic [1:0] exp_d;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        s_op0 = 8'd2; b_op0 = 8'd3;
        s_op1 = 8'd4; b_op1 = 8'd5;
        req   = 2'b11;
        n     = 0;
        for (int c = 1; c <= 100 && n < 4; c++) begin
            tick();
            if (done != 2'b00) begin
`ifdef MULT_FIXED_PRIO_EN
                exp_d = 2'b01;
`else
                exp_d = ((n % 2) == 1) ? 2'b10 : 2'b01;
`endif
                chk_cnt++;
                if (done !== exp_d) $display("FAIL contention_owner op%0d: got %b want %b", n, done, exp_d);
                else pass_cnt++;
                chk_cnt++;
                if (c != 18 + 19 * n) $display("FAIL contention_spacing op%0d: got cycle %0d want %0d", n, c, 18 + 19 * n);
                else pass_cnt++;
                n++;
                if (n == 4) req = 2'b00;
            end
        end
        chk_cnt++;
        if (n != 4) $display("FAIL contention_timeout: got %0d dones want 4", n);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL contention_idle: got busy %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        s_op0 = 8'd7;
        b_op0 = 8'd3;
        req   = 2'b01;
        for (int c = 1; c <= 9; c++) tick();
        Reset = 1'b1;
        tick();
        chk_cnt++;
        if (vec !== 11'b0) $display("FAIL midreset_outputs: got %b want %b", vec, 11'b0);
        else pass_cnt++;
        Reset = 1'b0;
        req   = 2'b11;
        for (int c = 11; c <= 29; c++) begin
            tick();
            chk_cnt++;
            if (vec !== exp_vec(c - 10, 1'b0, 8'd3))
                $display("FAIL midreset_regrant c%0d: got %b want %b", c, vec, exp_vec(c - 10, 1'b0, 8'd3));
            else pass_cnt++;
            if (c == 28) begin
                chk_cnt++;
                if (product !== 16'd21) $display("FAIL midreset_product: got %h want %h", product, 16'd21);
                else pass_cnt++;
                req = 2'b00;
            end
        end
    endtask

    task automatic test_early_drop();
        int n_shift;
        s_op0   = 8'hFE;
        b_op0   = 8'h04;
        req     = 2'b01;
        n_shift = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 1) req = 2'b00;
            if (shift === 1'b1) n_shift++;
            chk_cnt++;
            if (vec !== exp_vec(c, 1'b0, 8'h04))
                $display("FAIL drop_ctrl c%0d: got %b want %b", c, vec, exp_vec(c, 1'b0, 8'h04));
            else pass_cnt++;
            if (c == 18) begin
                chk_cnt++;
                if (product !== 16'hFFF8) $display("FAIL drop_product: got %h want %h", product, 16'hFFF8);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (n_shift != 8) $display("FAIL drop_shift_count: got %0d want 8", n_shift);
        else pass_cnt++;
    endtask

    task automatic test_zero_mult();
        int n_shift;
        int n_arith;
        s_op1   = 8'h55;
        b_op1   = 8'h00;
        req     = 2'b10;
        n_shift = 0;
        n_arith = 0;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (shift === 1'b1) n_shift++;
            if (add !== 1'b0 || sub !== 1'b0) n_arith++;
            chk_cnt++;
            if (vec !== exp_vec(c, 1'b1, 8'h00))
                $display("FAIL zero_ctrl c%0d: got %b want %b", c, vec, exp_vec(c, 1'b1, 8'h00));
            else pass_cnt++;
            if (c == 18) begin
                chk_cnt++;
                if (product !== 16'h0000) $display("FAIL zero_product: got %h want %h", product, 16'h0000);
                else pass_cnt++;
                req = 2'b00;
            end
        end
        chk_cnt++;
        if (n_shift != 8 || n_arith != 0)
            $display("FAIL zero_counts: got shifts %0d arith %0d want 8 0", n_shift, n_arith);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_contention();
        test_mid_reset();
        test_early_drop();
        test_zero_mult();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mult_arb_seq.md
Name: mult_arb_seq

Overview:
- Sequencer and two-port arbiter for the shared shift-add signed multiplier datapath: the X/A/B shift registers, the adder/subtractor and the operand-select mux.
- Grants the datapath to one of two requesters and drives the clear/load/add/sub/shift control strobes for a full WIDTH-bit signed multiply.
- Pulses a done strobe to the owner when the product is valid in {A,B}.
- Sits between the top-level request sources (switch/run logic, a second client) and the datapath registers.

Parameters:
- WIDTH, 8, operand width; number of add/shift iterations (must be >= 2).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; held high until matching done bit pulses.
- M  in  1  datapath B[0] (current multiplier LSB).
- gnt  out  2  one-hot grant; held from LOAD through DONE inclusive.
- sel  out  1  operand-mux select = current owner index (0/1).
- clr_xa  out  1  clear X and A registers.
- ld_b  out  1  load B from the selected requester's operand.
- add  out  1  A <= A + S (X gets sign extension).
- sub  out  1  A <= A - S.
- shift  out  1  arithmetic right shift of {X,A,B}.
- done  out  2  one-cycle pulse to owner; product valid in {A,B} that cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE, cnt=0, owner=0, last_owner=1. All outputs 0.
- State register: cnt is a $clog2(WIDTH)-bit iteration counter. Outputs are decoded from state, cnt, owner and M (Moore apart from M on add/sub).
- IDLE:
  - no strobes;
  - if req!=0: pick winner, latch owner, go to LOAD;
  - else stay.
- Arbitration (round robin):
  - single requester wins;
  - both requesting: winner = ~last_owner;
  - last_owner <= owner on entry to DONE.
- LOAD: clr_xa=1, ld_b=1 (same cycle); cnt<=0; go to ADD.
- ADD:
  - add = M & (cnt != WIDTH-1);
  - sub = M & (cnt == WIDTH-1);
  - never both;
  - go to SHIFT.
- SHIFT:
  - shift=1;
  - if cnt==WIDTH-1, go to DONE;
  - else cnt<=cnt+1 and go to ADD.
- DONE: done[owner]=1 for exactly one cycle; go to IDLE.
- gnt[owner] and sel are valid in LOAD, ADD, SHIFT and DONE; both are 0 and sel=0 in IDLE.
- Latency (WIDTH=8): req sampled in IDLE at cycle 0.
  - LOAD in cycle 1.
  - ADD in cycles 2,4,…,16; SHIFT in cycles 3,5,…,17.
  - DONE in cycle 18 (total 2*WIDTH+3 cycles including IDLE).
  - Next grant possible from IDLE in cycle 19.
- Request dropped mid-operation: the operation still runs to completion and done still pulses; a request is not re-sampled until IDLE.
- New request from the non-owner while busy: ignored until IDLE, then arbitrated normally.
- Reset asserted in any state: next cycle is IDLE with reset values; no done pulse for the aborted operation.
- Invariants:
  - at most one of clr_xa/add/sub/shift-phase states is active;
  - add and sub are never both 1;
  - gnt is one-hot or zero;
  - done is only ever nonzero in DONE.

Optional Feature:
- MULT_FIXED_PRIO_EN
  - Defined: fixed priority; req[0] always wins when both requesters are active; last_owner is unused.
  - Undefined (default): round-robin arbitration as specified above.

Test Plan:
- Basic multiply: Reset then release; req=01, operands S=7, B=3 → gnt=01 cycles 1–18; sub never asserted; done=01 in cycle 18; {A,B}=16'd21; busy falls cycle 19.
- Signed multiply: req=10, S=8'h05, B=8'hFD (−3) → sub=1 in cycle 16 (M=1 at cnt=7); done=10 at cycle 18; {A,B}=16'hFFF1 (−15).
- Contention: both req held continuously → grants alternate 01,10,01,10 on successive operations, each done 19 cycles apart. With MULT_FIXED_PRIO_EN → 01 every time.
- Mid-operation reset: req=01; assert Reset in cycle 9 → cycle 10: state IDLE, all outputs 0, no done; next req=11 grants requester 0 (last_owner reset to 1).
- Early drop: req=01 in cycle 0 only, req=00 from cycle 1 → full 8 ADD/SHIFT pairs execute; done=01 in cycle 18; no second grant.
- Zero multiplier: B=8'h00 → add and sub stay 0 for all 8 iterations; shift pulses 8 times; product 16'h0000.
